aes_dft_encrypt_selftest: RTL
=============================

// Module: aes_dft_encrypt_selftest
// PURPOSE
//   Board-level self-test for the iterative AES-128 encrypt core, the encrypt-side counterpart of the decrypt self-test.
//   After reset release, samples sw[2:0], loads key/plaintext vector sw from an internal ROM, runs aes128_enc_core once,
//   compares the ciphertext to the expected value and latches a green or red LED. Top level on the Atlys board (100 MHz).
// PARAMETERS
//   TIMEOUT_CYCLES  200  max cycles in WAIT_CORE before a forced fail (must exceed core latency, 11 rounds + overhead)
//   START_DELAY     4    idle cycles after reset release before sw is sampled (switch/reset settle)
// PORTS
//   clk          in   1    system clock, 100 MHz
//   rst_n        in   1    asynchronous active-low reset; its release starts one test run
//   sw           in   3    test-vector select 0..7
//   led_success  out  1    high: ciphertext matched (latched)
//   led_fail     out  1    high: mismatch or timeout (latched)
// BEHAVIOUR
//   Sub-core: aes128_enc_core(clk, rst_n, start, key[127:0], pt[127:0], ct[127:0], done). start is a 1-cycle pulse.
//     done is a 1-cycle pulse with ct valid in the same cycle.
//   Reset (async, rst_n=0): FSM=IDLE, delay cnt=0, timeout cnt=0, start=0, led_success=0, led_fail=0, vector regs=0.
//   FSM: IDLE -(START_DELAY cycles)-> LOAD -> START -> WAIT_CORE -> CHECK -> DONE.
//     LOAD: register sel=sw, key/pt/exp from ROM[sel]. sw changes after LOAD have no effect until the next reset.
//     START: assert start for exactly one cycle.
//     WAIT_CORE: count cycles. On done, capture ct -> CHECK.
//       Timeout cnt reaches TIMEOUT_CYCLES-1 without done: go to DONE with fail=1.
//       done and timeout in the same cycle: done wins.
//     CHECK: 128-bit equality ct==exp, registered. Equal: success=1, otherwise fail=1. -> DONE.
//     DONE: terminal. Exactly one LED high, held until rst_n asserts. Further done pulses are ignored.
//   LEDs are registered, never both high, both 0 from reset until DONE.
//   Latency from rst_n rise to LED = START_DELAY + 2 + core latency + 2 cycles.
//   Reset mid-run: immediate async abort, LEDs cleared. A new run starts on release and samples the current sw.
//   ROM (key / pt -> expected ct):
//     0  000102030405060708090a0b0c0d0e0f / 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a
//     1  2b7e151628aed2a6abf7158809cf4f3c / 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32
//     2  2b7e...4f3c / 6bc1bee22e409f96e93d7e117393172a -> 3ad77bb40d7a3660a89ecaf32466ef97
//     3  2b7e...4f3c / ae2d8a571e03ac9c9eb76fac45af8e51 -> f5d3d58503b9699de785895a96fdbaaf
//     4  2b7e...4f3c / 30c81c46a35ce411e5fbc1191a0a52ef -> 43b1cd7f598ece23881b00e3ed030688
//     5  2b7e...4f3c / f69f2445df4f9b17ad2b417be66c3710 -> 7b0c785e27e8ad3f8223207104725dd4
//     6  all-zero key / all-zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e
//     7  vector 0 with expected ct bit0 inverted (...c55b): deliberate negative test, must light led_fail
// CONFIGURATION
//   AES_ROUNDTRIP_CHECK_EN defined:
//     After an encrypt match, CHECK feeds ct into aes128_dec_core (same handshake, same key) and waits in WAIT_DEC.
//     The decrypt wait has its own TIMEOUT_CYCLES guard.
//     success=1 only if the decrypted block == pt as well. Any mismatch or timeout sets fail=1.
//     An encrypt mismatch skips decryption and sets fail=1 directly. Latency grows by decrypt latency + 3 cycles.
//   AES_ROUNDTRIP_CHECK_EN undefined: no decrypt core is instantiated; the FSM is as described above.
// TESTING
//   Bench: 10 ns clock, 5-cycle rst_n pulse per case, 200-cycle LED wait.
//   1 sw=0..6, reset pulse each -> led_success=1, led_fail=0 within 200 cycles, for all 7 cases.
//   2 sw=7, reset pulse -> led_fail=1, led_success=0. Expected-ct corruption is caught.
//   3 sw=1, change sw to 7 two cycles after LOAD -> still led_success=1. sw is sampled once.
//   4 sw=0, assert rst_n mid WAIT_CORE for 3 cycles -> both LEDs 0 during reset. A fresh run after release ends success.
//   5 Core stubbed to never pulse done -> led_fail=1 exactly TIMEOUT_CYCLES cycles after START.
//   6 With AES_ROUNDTRIP_CHECK_EN, sw=6 -> success. Force the decrypt output bit0 flipped -> led_fail=1.

Source files
------------

// File: rtl/aes_dft_encrypt_selftest.sv
// Board self-test: encrypts one ROM vector picked by sw with an iterative AES-128 core and latches a pass/fail LED.
// Optional build macro AES_ROUNDTRIP_CHECK_EN adds a decrypt round trip before success is declared.

package aes_dft_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one key_step; words are peeled back from the top so each uses its older neighbour.
  function automatic logic [127:0] key_unstep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // State bytes are column-major: byte 4*c+r sits at bits [127-8*(4*c+r) -: 8].
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return t ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    t = t ^ rk;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                             gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                             gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                             gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
    end
    return t;
  endfunction

endpackage

// One round per clock with on-the-fly key expansion; done pulses 10 cycles after start is sampled.
module aes128_enc_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic [127:0] ct,
  output logic         done
);
  import aes_dft_pkg::*;

  logic [127:0] state_q, rk_q, rk_next;
  logic [7:0]   rc_q;
  logic [3:0]   round_q;
  logic         busy_q, done_q;

  assign rk_next = key_step(rk_q, rc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rk_q    <= '0;
      rc_q    <= 8'h00;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= pt ^ key;
        rk_q    <= key;
        rc_q    <= 8'h01;
        round_q <= 4'd1;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        state_q <= enc_round(state_q, rk_next, round_q == 4'd10);
        rk_q    <= rk_next;
        rc_q    <= xtime(rc_q);
        if (round_q == 4'd10) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  assign ct   = state_q;
  assign done = done_q;
endmodule

`ifdef AES_ROUNDTRIP_CHECK_EN
// Expands the key forward to round 10 first, then walks the schedule backwards one round per clock.
module aes128_dec_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic [127:0] pt,
  output logic         done
);
  import aes_dft_pkg::*;

  logic [127:0] state_q, rk_q, rk_fwd, rk_back;
  logic [7:0]   rc_q, rc_back;
  logic [3:0]   cnt_q;
  logic         expand_q, busy_q, done_q;

  assign rc_back = rc_q[0] ? (((rc_q ^ 8'h1b) >> 1) | 8'h80) : (rc_q >> 1);
  assign rk_fwd  = key_step(rk_q, rc_q);
  assign rk_back = key_unstep(rk_q, rc_back);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      rk_q     <= '0;
      rc_q     <= 8'h00;
      cnt_q    <= 4'd0;
      expand_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= ct;
        rk_q     <= key;
        rc_q     <= 8'h01;
        cnt_q    <= 4'd0;
        expand_q <= 1'b1;
        busy_q   <= 1'b1;
      end else if (busy_q && expand_q) begin
        rk_q <= rk_fwd;
        rc_q <= xtime(rc_q);
        if (cnt_q == 4'd9) begin
          expand_q <= 1'b0;
          state_q  <= state_q ^ rk_fwd;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else if (busy_q) begin
        state_q <= dec_round(state_q, rk_back, cnt_q == 4'd0);
        rk_q    <= rk_back;
        rc_q    <= rc_back;
        if (cnt_q == 4'd0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign pt   = state_q;
  assign done = done_q;
endmodule
`endif

module aes_dft_encrypt_selftest #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int START_DELAY    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  output logic       led_success,
  output logic       led_fail
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_CORE, CHECK,
`ifdef AES_ROUNDTRIP_CHECK_EN
    WAIT_DEC, CHECK_DEC,
`endif
    DONE
  } state_t;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // Each entry is {key, plaintext, expected ciphertext}; entry 7 is a deliberately wrong answer.
  function automatic logic [383:0] rom_vec(input logic [2:0] sel);
    case (sel)
      3'd0: return {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      3'd1: return {KEY_FIPS, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
      3'd2: return {KEY_FIPS, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
      3'd3: return {KEY_FIPS, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
      3'd4: return {KEY_FIPS, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688};
      3'd5: return {KEY_FIPS, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};
      3'd6: return {128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      default: return {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                       128'h69c4e0d86a7b0430d8cdb78070b4c55b};
    endcase
  endfunction

  state_t       state;
  logic [15:0]  delay_cnt, tmo_cnt;
  logic [2:0]   sel_q;
  logic [127:0] ct_q;
  logic         core_start, core_done;
  logic [127:0] core_ct;
  logic [383:0] vec;
  logic [127:0] vec_key, vec_pt, vec_exp;

  // The ROM is addressed by the latched selection, so later sw activity cannot reach the core.
  assign vec = rom_vec(sel_q);
  assign {vec_key, vec_pt, vec_exp} = vec;

  aes128_enc_core u_enc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .key   (vec_key),
    .pt    (vec_pt),
    .ct    (core_ct),
    .done  (core_done)
  );

`ifdef AES_ROUNDTRIP_CHECK_EN
  logic         dec_start, dec_done;
  logic [127:0] dec_pt;

  aes128_dec_core u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dec_start),
    .key   (vec_key),
    .ct    (ct_q),
    .pt    (dec_pt),
    .done  (dec_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_cnt   <= '0;
      tmo_cnt     <= '0;
      sel_q       <= 3'd0;
      ct_q        <= '0;
      core_start  <= 1'b0;
      led_success <= 1'b0;
      led_fail    <= 1'b0;
`ifdef AES_ROUNDTRIP_CHECK_EN
      dec_start   <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
`ifdef AES_ROUNDTRIP_CHECK_EN
      dec_start  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (delay_cnt == 16'(START_DELAY - 1)) state <= LOAD;
          else delay_cnt <= delay_cnt + 16'd1;
        end
        LOAD: begin
          sel_q      <= sw;
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            ct_q  <= core_ct;
            state <= CHECK;
          end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            led_fail <= 1'b1;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        CHECK: begin
          if (ct_q == vec_exp) begin
`ifdef AES_ROUNDTRIP_CHECK_EN
            dec_start <= 1'b1;
            tmo_cnt   <= '0;
            state     <= WAIT_DEC;
`else
            led_success <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            led_fail <= 1'b1;
            state    <= DONE;
          end
        end
`ifdef AES_ROUNDTRIP_CHECK_EN
        WAIT_DEC: begin
          if (dec_done) begin
            ct_q  <= dec_pt;
            state <= CHECK_DEC;
          end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            led_fail <= 1'b1;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        CHECK_DEC: begin
          if (ct_q == vec_pt) led_success <= 1'b1;
          else led_fail <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
